// File: rtl/prf_free_list.sv
// Circular free list of physical register tags for rename, with speculative/committed heads.
// Define FREELIST_CHECK_EN to build the in-list tracking vector and the sticky list_err flag.
module prf_free_list #(
  parameter int unsigned PRF_NUM = 64,
  parameter int unsigned ARF_NUM = 32,
  parameter int unsigned DEPTH   = PRF_NUM - ARF_NUM,
  localparam int unsigned PW = $clog2(PRF_NUM),
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc_req_0,
  input  logic          alloc_req_1,
  output logic          alloc_ok,
  output logic [PW-1:0] alloc_num_0,
  output logic [PW-1:0] alloc_num_1,
  input  logic          commit_alloc_0,
  input  logic          commit_alloc_1,
  input  logic          commit_free_0,
  input  logic          commit_free_1,
  input  logic [PW-1:0] commit_free_num_0,
  input  logic [PW-1:0] commit_free_num_1,
  output logic [CW-1:0] free_count,
  output logic          list_err
);

  // Pointer increment by 0..2 that wraps modulo DEPTH, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
    logic [AW:0] s;
    s = (AW+1)'(p) + (AW+1)'(n);
    if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  logic [PW-1:0] list_q [DEPTH];
  logic [AW-1:0] head_q, chead_q, tail_q;
  logic [CW-1:0] scount_q, ccount_q;

  logic [1:0]    nreq, granted, nfree, ncalloc;
  logic          rel_0, rel_1;
  logic [AW-1:0] head_d, chead_d, tail_d, wptr_1;
  logic [CW-1:0] scount_d, ccount_d;

  always_comb begin
    nreq     = 2'(alloc_req_0) + 2'(alloc_req_1);
    alloc_ok = (scount_q >= CW'(nreq));
    granted  = (alloc_ok && !flush) ? nreq : 2'd0;
    // Tag 0 is never a real free register, so releasing it is a no-op.
    rel_0    = commit_free_0 && (commit_free_num_0 != '0);
    rel_1    = commit_free_1 && (commit_free_num_1 != '0);
    nfree    = 2'(rel_0) + 2'(rel_1);
    ncalloc  = 2'(commit_alloc_0) + 2'(commit_alloc_1);
    chead_d  = ptr_add(chead_q, ncalloc);
    tail_d   = ptr_add(tail_q, nfree);
    wptr_1   = ptr_add(tail_q, 2'(rel_0));
    ccount_d = ccount_q - CW'(ncalloc) + CW'(nfree);
    if (flush) begin
      head_d   = chead_d;
      scount_d = ccount_d;
    end else begin
      head_d   = ptr_add(head_q, granted);
      scount_d = scount_q - CW'(granted) + CW'(nfree);
    end
  end

  assign alloc_num_0 = list_q[head_q];
  assign alloc_num_1 = list_q[ptr_add(head_q, 2'(alloc_req_0))];
  assign free_count  = scount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) list_q[i] <= PW'(ARF_NUM + i);
      head_q   <= '0;
      chead_q  <= '0;
      tail_q   <= '0;
      scount_q <= CW'(DEPTH);
      ccount_q <= CW'(DEPTH);
    end else begin
      if (rel_0) list_q[tail_q] <= commit_free_num_0;
      if (rel_1) list_q[wptr_1] <= commit_free_num_1;
      head_q   <= head_d;
      chead_q  <= chead_d;
      tail_q   <= tail_d;
      scount_q <= scount_d;
      ccount_q <= ccount_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic [PRF_NUM-1:0] in_list_q, in_list_d, cin_list_q, cin_list_d;
  logic               err_q, err_d;
  logic [CW:0]        s_wide;

  always_comb begin
    // Committed copy drops the entries that chead moves past.
    cin_list_d = cin_list_q;
    if (ncalloc != 2'd0) cin_list_d[list_q[chead_q]] = 1'b0;
    if (ncalloc == 2'd2) cin_list_d[list_q[ptr_add(chead_q, 2'd1)]] = 1'b0;
    if (rel_0) cin_list_d[commit_free_num_0] = 1'b1;
    if (rel_1) cin_list_d[commit_free_num_1] = 1'b1;

    in_list_d = in_list_q;
    if (alloc_ok && !flush) begin
      if (alloc_req_0) in_list_d[alloc_num_0] = 1'b0;
      if (alloc_req_1) in_list_d[alloc_num_1] = 1'b0;
    end
    if (rel_0) in_list_d[commit_free_num_0] = 1'b1;
    if (rel_1) in_list_d[commit_free_num_1] = 1'b1;
    if (flush) in_list_d = cin_list_d;

    s_wide = (CW+1)'(scount_q) - (CW+1)'(granted) + (CW+1)'(nfree);
    err_d  = err_q
           | (rel_0 && in_list_q[commit_free_num_0])
           | (rel_1 && in_list_q[commit_free_num_1])
           | (rel_0 && rel_1 && (commit_free_num_0 == commit_free_num_1))
           | (s_wide > (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PRF_NUM; i++) begin
        in_list_q[i]  <= (i >= ARF_NUM);
        cin_list_q[i] <= (i >= ARF_NUM);
      end
      err_q <= 1'b0;
    end else begin
      in_list_q  <= in_list_d;
      cin_list_q <= cin_list_d;
      err_q      <= err_d;
    end
  end

  assign list_err = err_q;
`else
  assign list_err = 1'b0;
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list with hand-computed expectations (default 64/32 config).
module tb_prf_free_list;

  logic       clk = 1'b0;
  logic       rst, flush, alloc_req_0, alloc_req_1, alloc_ok;
  logic [5:0] alloc_num_0, alloc_num_1, commit_free_num_0, commit_free_num_1, free_count;
  logic       commit_alloc_0, commit_alloc_1, commit_free_0, commit_free_1, list_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  prf_free_list dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .alloc_req_0       (alloc_req_0),
    .alloc_req_1       (alloc_req_1),
    .alloc_ok          (alloc_ok),
    .alloc_num_0       (alloc_num_0),
    .alloc_num_1       (alloc_num_1),
    .commit_alloc_0    (commit_alloc_0),
    .commit_alloc_1    (commit_alloc_1),
    .commit_free_0     (commit_free_0),
    .commit_free_1     (commit_free_1),
    .commit_free_num_0 (commit_free_num_0),
    .commit_free_num_1 (commit_free_num_1),
    .free_count        (free_count),
    .list_err          (list_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then let outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_req_0 = 0; alloc_req_1 = 0;
    commit_alloc_0 = 0; commit_alloc_1 = 0;
    commit_free_0 = 0; commit_free_1 = 0;
    commit_free_num_0 = '0; commit_free_num_1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    rst = 1;
    idle();

    // Reset state and dual allocation
    do_reset();
    check_eq("rst_free_count", free_count, 32);
    check_eq("rst_alloc_num_0", alloc_num_0, 32);
    check_eq("rst_list_err", list_err, 0);
    alloc_req_0 = 1; alloc_req_1 = 1; #1;
    check_eq("dual_ok", alloc_ok, 1);
    check_eq("dual_num_0", alloc_num_0, 32);
    check_eq("dual_num_1", alloc_num_1, 33);
    tick();
    idle(); #1;
    check_eq("dual_free_count", free_count, 30);
    check_eq("dual_next_num_0", alloc_num_0, 34);

    // Lone slot-1 request takes the head entry
    do_reset();
    alloc_req_1 = 1; #1;
    check_eq("lone1_num_1", alloc_num_1, 32);
    tick();
    idle(); #1;
    check_eq("lone1_free_count", free_count, 31);

    // Exhaust the list, stall, then a release becomes allocatable one cycle later
    do_reset();
    alloc_req_0 = 1; alloc_req_1 = 1;
    for (int i = 0; i < 16; i++) tick();
    idle();
    alloc_req_0 = 1; commit_free_0 = 1; commit_free_num_0 = 6'd5; #1;
    check_eq("empty_free_count", free_count, 0);
    check_eq("empty_ok", alloc_ok, 0);
    check_eq("empty_head_num_0", alloc_num_0, 32);
    tick();
    commit_free_0 = 0; commit_free_num_0 = '0; #1;
    check_eq("refill_ok", alloc_ok, 1);
    check_eq("refill_num_0", alloc_num_0, 5);
    check_eq("refill_free_count", free_count, 1);
    alloc_req_1 = 1; #1;
    check_eq("one_left_dual_ok", alloc_ok, 0);
    tick();
    idle(); #1;
    check_eq("stall_keeps_count", free_count, 1);
    check_eq("stall_keeps_head", alloc_num_0, 5);

    // Allocate 4, commit 1, flush back to committed head
    do_reset();
    alloc_req_0 = 1; alloc_req_1 = 1;
    tick(); tick();
    idle(); commit_alloc_0 = 1;
    tick();
    idle(); flush = 1;
    tick();
    idle(); #1;
    check_eq("flush_free_count", free_count, 31);
    check_eq("flush_num_0", alloc_num_0, 33);

    // Flush composed with alloc, commit and release in the same cycle
    do_reset();
    alloc_req_0 = 1; alloc_req_1 = 1;
    tick();
    flush = 1; commit_alloc_0 = 1; commit_free_0 = 1; commit_free_num_0 = 6'd7;
    tick();
    idle(); #1;
    check_eq("fcomp_free_count", free_count, 32);
    check_eq("fcomp_num_0", alloc_num_0, 33);
    alloc_req_0 = 1; alloc_req_1 = 1;
    for (int i = 0; i < 15; i++) tick();
    alloc_req_1 = 0; #1;
    check_eq("fcomp_last_orig", alloc_num_0, 63);
    tick();
    idle(); #1;
    check_eq("fcomp_tail_7", alloc_num_0, 7);
    check_eq("fcomp_count_1", free_count, 1);

    // Alloc and release compose without flush
    do_reset();
    alloc_req_0 = 1; alloc_req_1 = 1; commit_free_1 = 1; commit_free_num_1 = 6'd9;
    tick();
    idle(); #1;
    check_eq("compose_free_count", free_count, 31);
    check_eq("compose_list_err", list_err, 0);

    // Release of tag 0 is dropped
    do_reset();
    alloc_req_0 = 1;
    tick();
    idle(); commit_free_0 = 1; commit_free_num_0 = '0;
    tick();
    idle(); #1;
    check_eq("rel0_free_count", free_count, 31);
    check_eq("rel0_list_err", list_err, 0);

`ifdef FREELIST_CHECK_EN
    // Releasing a tag already in the list is flagged sticky until reset
    do_reset();
    commit_free_0 = 1; commit_free_num_0 = 6'd40;
    tick();
    idle(); #1;
    check_eq("dup_err_set", list_err, 1);
    tick(); tick();
    check_eq("dup_err_held", list_err, 1);
    do_reset();
    check_eq("dup_err_cleared", list_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
